ray_dispatcher: RTL
===================

# ray_dispatcher

Frame-level camera ray source that sits in front of `pipelined_normalization`. It scans an IMG_W×IMG_H pixel grid in raster order and generates one unnormalized pinhole-camera direction per pixel. Each direction is issued as a single-cycle `norm_start`/`norm_dir` strobe, and a credit counter keeps the number of rays in flight at or below MAX_INFLIGHT. Returned normalized directions arrive in order and are re-tagged with their pixel coordinates for the downstream intersection stage.

## Interface
Parameters:
- WIDTH, `WIDTH, fixed-point word width (signed)
- Q_BITS, `Q_BITS, fractional bits
- IMG_W, 64, image width in pixels (≥2)
- IMG_H, 64, image height in pixels (≥2)
- FOCAL, 64, focal length in pixels (integer)
- MAX_INFLIGHT, 32, maximum issued-but-unreturned rays (≤ normalizer buffer depth)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- frame_start  in  1  pulse; begins a frame when idle
- busy  out  1  high from accepted frame_start until frame_done
- frame_done  out  1  one-cycle pulse after last ray returned
- norm_start  out  1  issue strobe to normalizer
- norm_dir  out  RayDirection  direction issued with norm_start
- norm_valid  in  1  normalizer valid_out
- norm_dir_in  in  RayDirection  normalizer output
- ray_valid  out  1  normalized ray available
- ray_dir  out  RayDirection  normalized direction
- ray_px  out  $clog2(IMG_W)  pixel column
- ray_py  out  $clog2(IMG_H)  pixel row
- ray_last  out  1  marks final pixel of frame
- err_unexpected  out  1  sticky; norm_valid seen with zero in flight

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE on frame_start. Issue and return counters clear; inflight clears.
- ISSUE: each cycle with inflight < MAX_INFLIGHT, drive norm_start=1 for the current issue pixel, then advance (px,py) in raster order: px wraps at IMG_W−1 and py increments. ISSUE → DRAIN after the pixel (IMG_W−1, IMG_H−1) issues.
- DRAIN → DONE when inflight==0 and all IMG_W·IMG_H rays have returned. DONE pulses frame_done for one cycle, then goes to IDLE.
- Direction for pixel (px,py), computed in WIDTH-bit signed arithmetic (pixel-centre offsets):
  - x = (2·px+1−IMG_W)·2^(Q_BITS−1)
  - y = (IMG_H−1−2·py)·2^(Q_BITS−1)
  - z = −FOCAL·2^Q_BITS
  - Parameters must fit in WIDTH; no saturation.
- Inflight update: increment on issue, decrement on norm_valid, unchanged when both occur. The issue condition uses the registered inflight only, so the credit check is conservative.
- Return path: on each norm_valid, output the return-counter pixel with norm_dir_in and advance the return counter. ray_last=1 for (IMG_W−1, IMG_H−1).
- norm_valid with inflight==0: result discarded, err_unexpected set (cleared only by reset). norm_valid outside a frame is handled the same way.
- frame_start while busy: ignored.
- No backpressure on ray_*; the consumer must accept every cycle.

## Timing
- Reset values: state IDLE; busy, frame_done, norm_start, ray_valid, ray_last, err_unexpected = 0; norm_dir, ray_dir, ray_px, ray_py = 0; counters and inflight = 0.
- norm_start/norm_dir are registered. The first norm_start appears 1 cycle after the frame_start cycle, and busy rises in the same cycle.
- Issue rate is 1 ray/cycle when not credit-limited.
- ray_* are registered, 1 cycle after norm_valid.
- frame_done asserts 1 cycle after the last decrement. busy falls in the same cycle as frame_done.
- A reset mid-frame aborts with no frame_done. The normalizer shares the same reset so both ends flush together.

## Structure
- Add to Types.sv:
  - PixelRay typedef {RayDirection dir; px; py; last}
  - `IMG_W, `IMG_H, `FOCAL defaults
- Sub-module `raster_counter` (px/py counter with enable, clear, wrap, last flag), instantiated twice: issue side and return side.
- FSM, credit counter and direction arithmetic live in ray_dispatcher.

## Test plan
- IMG_W=4, IMG_H=2, Q_BITS=16, FOCAL=1, ideal normalizer model (fixed latency 5) -> first norm_dir = (−98304, 32768, −65536); 8 ray_valid in raster order; ray_last on (3,1); one frame_done pulse.
- MAX_INFLIGHT=4, model withholds norm_valid -> exactly 4 norm_start then a stall. Releasing one result -> exactly one more issue.
- Simultaneous issue and return every cycle at MAX_INFLIGHT−1 -> inflight constant, no overshoot above MAX_INFLIGHT.
- norm_valid injected in IDLE -> no ray_valid, err_unexpected=1 and stays set.
- frame_start pulsed mid-frame -> ignored; the frame completes with exactly IMG_W·IMG_H results.
- reset asserted after 3 issues -> all outputs return to reset values next cycle. A new frame_start restarts at pixel (0,0).

Source files
------------

// File: rtl/ray_dispatcher_pkg.sv
// ray_dispatcher_pkg
// Shared defaults, state encoding and record types for the camera ray
// dispatcher and its raster counters.
//   DEF_*        default parameter values for the dispatcher
//   ray_dir_t    one {x, y, z} direction at the default word width
//   pixel_ray_t  a returned direction tagged with its pixel coordinates
//   disp_state_t dispatcher FSM states
//   cnt_bits()   register width needed to hold 0..max_val
package ray_dispatcher_pkg;

  localparam int DEF_WIDTH        = 32;
  localparam int DEF_Q_BITS       = 16;
  localparam int DEF_IMG_W        = 64;
  localparam int DEF_IMG_H        = 64;
  localparam int DEF_FOCAL        = 64;
  localparam int DEF_MAX_INFLIGHT = 32;

  typedef struct packed {
    logic signed [DEF_WIDTH-1:0] x;
    logic signed [DEF_WIDTH-1:0] y;
    logic signed [DEF_WIDTH-1:0] z;
  } ray_dir_t;

  typedef struct packed {
    ray_dir_t                       dir;
    logic [$clog2(DEF_IMG_W)-1:0]   px;
    logic [$clog2(DEF_IMG_H)-1:0]   py;
    logic                           last;
  } pixel_ray_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } disp_state_t;

  function automatic int cnt_bits(input int max_val);
    int b;
    b = $clog2(max_val + 1);
    return (b < 1) ? 1 : b;
  endfunction

endpackage

// File: rtl/ray_dispatcher_raster_counter.sv
// raster_counter
// Pixel position counter walking a COLS x ROWS grid in raster order.
//   clk, reset  clock and synchronous active-high reset
//   clear       restart at (0,0)
//   enable      consume the current pixel and advance one position
//   px, py      current pixel (registered)
//   last        current pixel is (COLS-1, ROWS-1)
// clear and enable together mean the origin pixel is consumed in the same
// cycle, so the counter lands on the second pixel.
module raster_counter #(
  parameter int COLS = 64,
  parameter int ROWS = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    enable,
  output logic [$clog2(COLS)-1:0] px,
  output logic [$clog2(ROWS)-1:0] py,
  output logic                    last
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] PX_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] PY_MAX = RW'(ROWS - 1);

  logic [CW-1:0] px_base;
  logic [RW-1:0] py_base;

  assign px_base = clear ? '0 : px;
  assign py_base = clear ? '0 : py;
  assign last    = (px == PX_MAX) && (py == PY_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      px <= '0;
      py <= '0;
    end else if (enable) begin
      if (px_base == PX_MAX) begin
        px <= '0;
        py <= (py_base == PY_MAX) ? '0 : py_base + 1'b1;
      end else begin
        px <= px_base + 1'b1;
        py <= py_base;
      end
    end else if (clear) begin
      px <= '0;
      py <= '0;
    end
  end

endmodule

// File: rtl/ray_dispatcher.sv
// ray_dispatcher
// Scans an IMG_W x IMG_H grid in raster order, issues one pinhole-camera
// direction per pixel to the normalizer under a credit limit, and re-tags
// the in-order normalized results with their pixel coordinates.
//   clk, reset             clock and synchronous active-high reset
//   frame_start            begin a frame (only honoured in IDLE)
//   busy, frame_done       frame in progress / one-cycle completion pulse
//   norm_start, norm_dir   issue strobe and {x,y,z} direction to normalizer
//   norm_valid, norm_dir_in  normalizer result strobe and {x,y,z} data
//   ray_valid, ray_dir, ray_px, ray_py, ray_last  tagged result to consumer
//   err_unexpected         sticky: a result arrived with nothing in flight
// Directions are packed {x, y, z} with x in the most significant word.
//
// state | meaning
// IDLE  | waiting for frame_start; the accepting cycle issues pixel (0,0)
// ISSUE | issuing one pixel per cycle while credits remain
// DRAIN | all pixels issued, waiting for the remaining results
// DONE  | frame_done pulse, back to IDLE next cycle
module ray_dispatcher
  import ray_dispatcher_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int Q_BITS       = DEF_Q_BITS,
  parameter int IMG_W        = DEF_IMG_W,
  parameter int IMG_H        = DEF_IMG_H,
  parameter int FOCAL        = DEF_FOCAL,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     norm_start,
  output logic [3*WIDTH-1:0]       norm_dir,
  input  logic                     norm_valid,
  input  logic [3*WIDTH-1:0]       norm_dir_in,
  output logic                     ray_valid,
  output logic [3*WIDTH-1:0]       ray_dir,
  output logic [$clog2(IMG_W)-1:0] ray_px,
  output logic [$clog2(IMG_H)-1:0] ray_py,
  output logic                     ray_last,
  output logic                     err_unexpected
);

  localparam int PXW = $clog2(IMG_W);
  localparam int PYW = $clog2(IMG_H);
  localparam int IFW = cnt_bits(MAX_INFLIGHT);

  localparam logic [IFW-1:0]          MAX_IF  = IFW'(MAX_INFLIGHT);
  localparam logic signed [WIDTH-1:0] ONE_S   = WIDTH'(1);
  localparam logic signed [WIDTH-1:0] IMG_W_S = WIDTH'(IMG_W);
  localparam logic signed [WIDTH-1:0] IMG_H_S = WIDTH'(IMG_H);
  localparam logic signed [WIDTH-1:0] FOCAL_S = WIDTH'(FOCAL);
  localparam logic signed [WIDTH-1:0] DIR_Z   = -(FOCAL_S <<< Q_BITS);

  disp_state_t state;
  logic [IFW-1:0] inflight;
  logic           ret_done;

  logic           accept;
  logic           issue_fire;
  logic           ret_fire;
  logic           stray;

  logic [PXW-1:0] iss_px;
  logic [PYW-1:0] iss_py;
  logic           iss_last;
  logic [PXW-1:0] ret_px;
  logic [PYW-1:0] ret_py;
  logic           ret_last;
  logic [PXW-1:0] sel_px;
  logic [PYW-1:0] sel_py;

  logic signed [WIDTH-1:0] px_w;
  logic signed [WIDTH-1:0] py_w;
  logic signed [WIDTH-1:0] dir_x;
  logic signed [WIDTH-1:0] dir_y;

  // The accepting cycle already issues the origin pixel, so norm_start and
  // busy rise together one cycle after frame_start.
  assign accept     = (state == ST_IDLE) && frame_start;
  // Credit check looks only at the registered count; a same-cycle return
  // does not free a slot until the next cycle.
  assign issue_fire = accept || ((state == ST_ISSUE) && (inflight < MAX_IF));
  assign ret_fire   = norm_valid && (inflight != '0);
  assign stray      = norm_valid && (inflight == '0);

  raster_counter #(
    .COLS (IMG_W),
    .ROWS (IMG_H)
  ) u_issue_ctr (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (issue_fire),
    .px     (iss_px),
    .py     (iss_py),
    .last   (iss_last)
  );

  raster_counter #(
    .COLS (IMG_W),
    .ROWS (IMG_H)
  ) u_ret_ctr (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (ret_fire),
    .px     (ret_px),
    .py     (ret_py),
    .last   (ret_last)
  );

  assign sel_px = accept ? '0 : iss_px;
  assign sel_py = accept ? '0 : iss_py;
  assign px_w   = WIDTH'(sel_px);
  assign py_w   = WIDTH'(sel_py);

  // Pixel-centre offsets in half-pixel units, scaled by 2^(Q_BITS-1).
  assign dir_x = ((px_w <<< 1) + ONE_S - IMG_W_S) <<< (Q_BITS - 1);
  assign dir_y = (IMG_H_S - ONE_S - (py_w <<< 1)) <<< (Q_BITS - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      norm_start     <= 1'b0;
      norm_dir       <= '0;
      ray_valid      <= 1'b0;
      ray_dir        <= '0;
      ray_px         <= '0;
      ray_py         <= '0;
      ray_last       <= 1'b0;
      err_unexpected <= 1'b0;
      inflight       <= '0;
      ret_done       <= 1'b0;
    end else begin
      norm_start <= issue_fire;
      if (issue_fire) begin
        norm_dir <= {dir_x, dir_y, DIR_Z};
      end

      ray_valid <= ret_fire;
      ray_last  <= ret_fire && ret_last;
      if (ret_fire) begin
        ray_dir <= norm_dir_in;
        ray_px  <= ret_px;
        ray_py  <= ret_py;
      end

      if (stray) begin
        err_unexpected <= 1'b1;
      end

      if (accept) begin
        inflight <= IFW'(1);
      end else if (issue_fire && !ret_fire) begin
        inflight <= inflight + 1'b1;
      end else if (!issue_fire && ret_fire) begin
        inflight <= inflight - 1'b1;
      end

      if (accept) begin
        ret_done <= 1'b0;
      end else if (ret_fire && ret_last) begin
        ret_done <= 1'b1;
      end

      frame_done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state <= ST_ISSUE;
            busy  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (issue_fire && iss_last) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((inflight == '0) && ret_done) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
